// File: rtl/wb_writer_if.sv
// Writeback request/response bundle for wb_writer: two producer request
// channels, the register-file write port, the forwarding lookup and the
// queue occupancy. The slave side is the writer itself.
interface wb_writer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ALU writeback request channel
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             alu_ready;

    // Load-return request channel
    logic             ld_valid;
    logic [4:0]       ld_rd;
    logic [31:0]      ld_data;
    logic             ld_ready;

    // Register-file write port
    logic [4:0]       writereg;
    logic [31:0]      writedata;
    logic             RegWrite;

    // Forwarding lookup
    logic [4:0]       query_reg;
    logic             query_hit;
    logic [31:0]      query_data;

    // Queue occupancy
    logic [CNT_W-1:0] count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  query_reg,
        output alu_ready, ld_ready,
        output writereg, writedata, RegWrite,
        output query_hit, query_data,
        output count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output query_reg,
        input  alu_ready, ld_ready,
        input  writereg, writedata, RegWrite,
        input  query_hit, query_data,
        input  count
    );
endinterface

// File: rtl/wb_writer.sv
// Writeback queue: merges ALU and load-return results into a single
// register-file write port, one write per cycle, with forwarding lookup
// over the pending entries. DEPTH must be 2, 4 or 8 (power of two, so the
// pointers wrap naturally).
module wb_writer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_writer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_slots;
    logic             ld_push;
    logic             alu_push;
    logic             pop;

    assign free_slots = CNT_W'(DEPTH) - count;
    assign head       = mem[rd_ptr];
    assign pop        = (count != '0);

    // Readiness from registered occupancy; the last free slot goes to the load.
    always_comb begin
        bus.ld_ready  = (free_slots != '0);
        bus.alu_ready = (free_slots >= CNT_W'(2)) ||
                        ((free_slots == CNT_W'(1)) && !bus.ld_valid);
    end

    // Accepted requests to r0 are swallowed here and never take a slot.
    always_comb begin
        ld_push  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd  != 5'd0);
        alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != 5'd0);
    end

    // Entry storage: load lands first, ALU behind it when both push together.
    // NOTE: storage is deliberately not reset; occupancy alone marks slots live.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            mem[wr_ptr] <= {bus.ld_rd, bus.ld_data};
        end
        if (alu_push) begin
            mem[wr_ptr + PTR_W'(ld_push)] <= {bus.alu_rd, bus.alu_data};
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    // NOTE: non-blocking so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(ld_push) + PTR_W'(alu_push);
            count  <= count + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);
        end
    end

    // Write port drives the head entry whenever the queue is non-empty.
    always_comb begin
        bus.RegWrite  = pop;
        bus.writereg  = pop ? head.rd   : 5'd0;
        bus.writedata = pop ? head.data : 32'd0;
        bus.count     = count;
    end

    // Forwarding lookup: scan oldest to newest so the newest match wins.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        bus.query_hit  = 1'b0;
        bus.query_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (bus.query_reg != 5'd0) &&
                (mem[rd_ptr + PTR_W'(i)].rd == bus.query_reg)) begin
                bus.query_hit  = 1'b1;
                bus.query_data = mem[rd_ptr + PTR_W'(i)].data;
            end
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: a DEPTH=4 and a DEPTH=2 instance run
// side by side against a queue-based reference model, plus a hand-computed
// vector table and directed reset/full-queue sequences.
module tb_wb_writer;
    localparam int D0 = 4;
    localparam int D1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_writer_if #(.DEPTH(D0)) bus0 ();
    wb_writer_if #(.DEPTH(D1)) bus1 ();

    wb_writer #(.DEPTH(D0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    wb_writer #(.DEPTH(D1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic [4:0]  qreg;
    } in_t;

    typedef struct packed {
        logic [3:0]  cnt;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        ar;
        logic        lr;
        logic        hit;
        logic [31:0] qd;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    in_t  stim [2];
    ent_t mq [2][$];
    logic acc_l [2];
    logic acc_a [2];
    vec_t tbl [$];

    int n_total = 0;
    int n_pass  = 0;
    int stalls  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic in_t mkin(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic [4:0] q);
        in_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.qreg = q;
        return v;
    endfunction

    function automatic out_t mkout(input logic [3:0] cnt, input logic rw, input logic [4:0] wr,
                                   input logic [31:0] wd, input logic ar, input logic lr,
                                   input logic hit, input logic [31:0] qd);
        out_t o;
        o.cnt = cnt; o.rw = rw; o.wr = wr; o.wd = wd;
        o.ar = ar; o.lr = lr; o.hit = hit; o.qd = qd;
        return o;
    endfunction

    task automatic add_row(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    task automatic drive();
        bus0.alu_valid = stim[0].av;  bus0.alu_rd = stim[0].ard;  bus0.alu_data = stim[0].adat;
        bus0.ld_valid  = stim[0].lv;  bus0.ld_rd  = stim[0].lrd;  bus0.ld_data  = stim[0].ldat;
        bus0.query_reg = stim[0].qreg;
        bus1.alu_valid = stim[1].av;  bus1.alu_rd = stim[1].ard;  bus1.alu_data = stim[1].adat;
        bus1.ld_valid  = stim[1].lv;  bus1.ld_rd  = stim[1].lrd;  bus1.ld_data  = stim[1].ldat;
        bus1.query_reg = stim[1].qreg;
    endtask

    function automatic out_t get_out(input int k);
        out_t o;
        if (k == 0) begin
            o = mkout(4'(bus0.count), bus0.RegWrite, bus0.writereg, bus0.writedata,
                      bus0.alu_ready, bus0.ld_ready, bus0.query_hit, bus0.query_data);
        end else begin
            o = mkout(4'(bus1.count), bus1.RegWrite, bus1.writereg, bus1.writedata,
                      bus1.alu_ready, bus1.ld_ready, bus1.query_hit, bus1.query_data);
        end
        return o;
    endfunction

    // Reference: a plain FIFO of pending writes; head is written each cycle.
    function automatic out_t model_out(input int k);
        out_t o;
        int   fr;
        o  = '0;
        fr = dep(k) - mq[k].size();
        o.cnt = 4'(mq[k].size());
        if (mq[k].size() != 0) begin
            o.rw = 1'b1;
            o.wr = mq[k][0].rd;
            o.wd = mq[k][0].data;
        end
        o.lr = (fr >= 1);
        o.ar = (fr >= 2) || ((fr == 1) && !stim[k].lv);
        if (stim[k].qreg != 5'd0) begin
            for (int j = 0; j < mq[k].size(); j++) begin
                if (mq[k][j].rd == stim[k].qreg) begin
                    o.hit = 1'b1;
                    o.qd  = mq[k][j].data;
                end
            end
        end
        return o;
    endfunction

    task automatic compare_out(input string tag, input out_t a, input out_t e);
        check({tag, ".count"},      32'(a.cnt), 32'(e.cnt));
        check({tag, ".RegWrite"},   32'(a.rw),  32'(e.rw));
        check({tag, ".writereg"},   32'(a.wr),  32'(e.wr));
        check({tag, ".writedata"},  a.wd,       e.wd);
        check({tag, ".alu_ready"},  32'(a.ar),  32'(e.ar));
        check({tag, ".ld_ready"},   32'(a.lr),  32'(e.lr));
        check({tag, ".query_hit"},  32'(a.hit), 32'(e.hit));
        check({tag, ".query_data"}, a.qd,       e.qd);
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            out_t a;
            a = get_out(k);
            compare_out($sformatf("dut%0d", k), a, model_out(k));
            check($sformatf("dut%0d.count_bound", k), 32'(int'(a.cnt) <= dep(k)), 32'd1);
        end
    endtask

    task automatic clock_step();
        for (int k = 0; k < 2; k++) begin
            out_t e;
            e = model_out(k);
            acc_l[k] = stim[k].lv && e.lr;
            acc_a[k] = stim[k].av && e.ar;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            ent_t t;
            if (mq[k].size() != 0) void'(mq[k].pop_front());
            if (acc_l[k] && stim[k].lrd != 5'd0) begin
                t.rd = stim[k].lrd; t.data = stim[k].ldat; mq[k].push_back(t);
            end
            if (acc_a[k] && stim[k].ard != 5'd0) begin
                t.rd = stim[k].ard; t.data = stim[k].adat; mq[k].push_back(t);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_cycle();
        drive();
        #1;
        check_model();
        clock_step();
    endtask

    task automatic set_both(input in_t v);
        stim[0] = v;
        stim[1] = v;
    endtask

    initial begin
        // Hand-computed vectors for DEPTH=4; outputs are those seen in the
        // cycle the row's inputs are applied (before the capturing edge).
        add_row(mkin(1, 5, 32'h1234, 0, 0, 0, 5),           mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(0, 0, 0, 0, 0, 0, 5),                   mkout(1, 1, 5, 32'h1234,   1, 1, 1, 32'h1234));
        add_row(mkin(1, 4, 32'hBBBB, 1, 3, 32'hAAAA, 0),     mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(0, 0, 0, 0, 0, 0, 4),                   mkout(2, 1, 3, 32'hAAAA,   1, 1, 1, 32'hBBBB));
        add_row(mkin(0, 0, 0, 0, 0, 0, 3),                   mkout(1, 1, 4, 32'hBBBB,   1, 1, 0, 0));
        add_row(mkin(1, 0, 32'hDEAD, 0, 0, 0, 0),            mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(0, 0, 0, 0, 0, 0, 0),                   mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(1, 7, 32'h2, 1, 7, 32'h1, 7),           mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(0, 0, 0, 0, 0, 0, 7),                   mkout(2, 1, 7, 32'h1,      1, 1, 1, 32'h2));
        add_row(mkin(0, 0, 0, 0, 0, 0, 7),                   mkout(1, 1, 7, 32'h2,      1, 1, 1, 32'h2));
        add_row(mkin(0, 0, 0, 0, 0, 0, 0),                   mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(1, 2, 32'h22, 1, 1, 32'h11, 2),         mkout(0, 0, 0, 0,          1, 1, 0, 0));
        add_row(mkin(1, 4, 32'h44, 1, 3, 32'h33, 2),         mkout(2, 1, 1, 32'h11,     1, 1, 1, 32'h22));
        add_row(mkin(1, 6, 32'h66, 1, 5, 32'h55, 4),         mkout(3, 1, 2, 32'h22,     0, 1, 1, 32'h44));
        add_row(mkin(1, 6, 32'h66, 0, 0, 0, 5),              mkout(3, 1, 3, 32'h33,     1, 1, 1, 32'h55));
        add_row(mkin(0, 0, 0, 0, 0, 0, 6),                   mkout(3, 1, 4, 32'h44,     1, 1, 1, 32'h66));
        add_row(mkin(0, 0, 0, 0, 0, 0, 0),                   mkout(2, 1, 5, 32'h55,     1, 1, 0, 0));
        add_row(mkin(0, 0, 0, 0, 0, 0, 0),                   mkout(1, 1, 6, 32'h66,     1, 1, 0, 0));
        add_row(mkin(0, 0, 0, 0, 0, 0, 0),                   mkout(0, 0, 0, 0,          1, 1, 0, 0));

        // Reset state, observed before any clock edge.
        set_both('0);
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            out_t a;
            a = get_out(k);
            check($sformatf("rst.dut%0d.count", k),     32'(a.cnt), 32'd0);
            check($sformatf("rst.dut%0d.RegWrite", k),  32'(a.rw),  32'd0);
            check($sformatf("rst.dut%0d.writereg", k),  32'(a.wr),  32'd0);
            check($sformatf("rst.dut%0d.writedata", k), a.wd,       32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table phase.
        for (int r = 0; r < tbl.size(); r++) begin
            set_both(tbl[r].i);
            drive();
            #1;
            compare_out($sformatf("tbl%0d", r), get_out(0), tbl[r].o);
            check_model();
            clock_step();
        end

        // DEPTH=2 fills completely; further requests must be refused.
        set_both(mkin(1, 2, 32'h2222, 1, 1, 32'h1111, 0));
        run_cycle();
        set_both(mkin(1, 4, 32'h4444, 1, 3, 32'h3333, 3));
        drive();
        #1;
        check("full.dut1.count",     32'(bus1.count),     32'd2);
        check("full.dut1.alu_ready", 32'(bus1.alu_ready), 32'd0);
        check("full.dut1.ld_ready",  32'(bus1.ld_ready),  32'd0);
        check_model();
        clock_step();
        set_both('0);
        for (int c = 0; c < 4; c++) run_cycle();

        // Asynchronous reset with three entries pending in the DEPTH=4 queue.
        set_both(mkin(1, 9, 32'h9999, 1, 8, 32'h8888, 0));
        run_cycle();
        set_both(mkin(1, 11, 32'hBB11, 1, 10, 32'hAA10, 0));
        run_cycle();
        set_both('0);
        drive();
        #1;
        check("pre_rst.dut0.count", 32'(bus0.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.dut0.count",     32'(bus0.count),     32'd0);
        check("async_rst.dut0.RegWrite",  32'(bus0.RegWrite),  32'd0);
        check("async_rst.dut0.writereg",  32'(bus0.writereg),  32'd0);
        check("async_rst.dut0.writedata", bus0.writedata,      32'd0);
        check("async_rst.dut1.RegWrite",  32'(bus1.RegWrite),  32'd0);
        mq[0].delete();
        mq[1].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive();
            #1;
            check($sformatf("post_rst%0d.dut0.RegWrite", c), 32'(bus0.RegWrite), 32'd0);
            check_model();
            clock_step();
        end

        // Both producers held valid; a refused request is held until taken.
        for (int k = 0; k < 2; k++) begin
            stim[k] = mkin(1, 5'($urandom_range(1, 31)), $urandom,
                           1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(0, 31)));
        end
        for (int c = 0; c < 200; c++) begin
            drive();
            #1;
            if (!bus0.alu_ready) stalls++;
            check_model();
            clock_step();
            for (int k = 0; k < 2; k++) begin
                if (acc_l[k]) begin
                    stim[k].lrd  = 5'($urandom_range(1, 31));
                    stim[k].ldat = $urandom;
                end
                if (acc_a[k]) begin
                    stim[k].ard  = 5'($urandom_range(1, 31));
                    stim[k].adat = $urandom;
                end
                stim[k].qreg = 5'($urandom_range(0, 31));
            end
        end
        check("saturate.dut0.alu_stalled", 32'(stalls > 0), 32'd1);

        // Fully random traffic over a small register range to force matches.
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                stim[k] = mkin(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                               5'($urandom_range(0, 7)));
            end
            run_cycle();
        end

        set_both('0);
        for (int c = 0; c < 6; c++) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
